// File: rtl/lcd_inst_pkg.sv
// Shared types and constants for the HD44780 Avalon controller: phase states,
// the power-up command ROM and the clear/home detection used to pick the execute wait.
package lcd_inst_pkg;

  typedef enum logic [2:0] {
    POWERUP,
    INIT,
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    EXEC
  } state_t;

  // Entry 0 is sent first: function set, display on, entry mode, clear.
  localparam logic [3:0][7:0] INIT_ROM = {8'h01, 8'h06, 8'h0C, 8'h38};

  localparam logic [7:0] LONG_CMD_MASK = 8'hFC;

  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data & LONG_CMD_MASK) == 8'h00) && (data != 8'h00);
  endfunction

  // Counter preload for an N-cycle phase; a zero-length phase still lasts one cycle.
  function automatic int phase_load(input int cycles);
    return (cycles > 0) ? cycles - 1 : 0;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_strobe_timer.sv
// Single down-counter shared by every timed phase. A start pulse in the first cycle
// of a phase carries the preload; done marks the last cycle of that phase.
module lcd_strobe_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] load,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (start) begin
      count <= (load == '0) ? '0 : load - CNT_W'(1);
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign done = start ? (load == '0) : (count == '0);

endmodule

// File: rtl/lcd_avalon_ctrl.sv
// Avalon-MM slave driving a parallel HD44780 character LCD: runs the power-up init,
// then forwards accepted byte writes with enable-strobe and execute-delay timing.
module lcd_avalon_ctrl
  import lcd_inst_pkg::*;
#(
  parameter int CLK_FREQ_HZ   = 50_000_000,
  parameter int POWERUP_US    = 15_000,
  parameter int T_SETUP_CYC   = 4,
  parameter int T_PULSE_CYC   = 12,
  parameter int T_HOLD_CYC    = 4,
  parameter int EXEC_SHORT_US = 40,
  parameter int EXEC_LONG_US  = 1640
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       address,
  input  logic       chipselect,
  input  logic       byteenable,
  input  logic       read,
  input  logic       write,
  input  logic [7:0] writedata,
  output logic       waitrequest,
  output logic [7:0] readdata,
  output logic [1:0] response,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic       lcd_on
);

  localparam int CYC_PER_US  = CLK_FREQ_HZ / 1_000_000;
  localparam int POWERUP_CYC = POWERUP_US * CYC_PER_US;
  localparam int SHORT_CYC   = EXEC_SHORT_US * CYC_PER_US;
  localparam int LONG_CYC    = EXEC_LONG_US * CYC_PER_US;
  localparam int MAX_WAIT    = max2(max2(max2(POWERUP_CYC, LONG_CYC), max2(SHORT_CYC, T_PULSE_CYC)),
                                    max2(max2(T_SETUP_CYC, T_HOLD_CYC), 1));
  localparam int CNT_W       = $clog2(MAX_WAIT) + 1;

  localparam logic [CNT_W-1:0] LD_POWERUP = CNT_W'(phase_load(POWERUP_CYC));
  localparam logic [CNT_W-1:0] LD_SETUP   = CNT_W'(phase_load(T_SETUP_CYC));
  localparam logic [CNT_W-1:0] LD_PULSE   = CNT_W'(phase_load(T_PULSE_CYC));
  localparam logic [CNT_W-1:0] LD_HOLD    = CNT_W'(phase_load(T_HOLD_CYC));
  localparam logic [CNT_W-1:0] LD_SHORT   = CNT_W'(phase_load(SHORT_CYC));
  localparam logic [CNT_W-1:0] LD_LONG    = CNT_W'(phase_load(LONG_CYC));

  state_t           state;
  logic             tmr_start;
  logic [CNT_W-1:0] tmr_load;
  logic             tmr_done;
  logic [2:0]       init_idx;
  logic             accept_wr;
  logic             unused_byteenable;

  lcd_strobe_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .start (tmr_start),
    .load  (tmr_load),
    .done  (tmr_done)
  );

  assign unused_byteenable = byteenable;

  // Only IDLE ever lets a transfer through; everything else stalls the master.
  assign waitrequest = reset | ~((state == IDLE) & chipselect & (read | write));
  assign accept_wr   = ~waitrequest & write;
  assign readdata    = (chipselect & read & ~write & ~address & ~reset) ?
                       {(state != IDLE), 7'b0} : 8'h00;
  assign response    = 2'b00;
  assign lcd_rw      = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= POWERUP;
      tmr_start <= 1'b1;
      tmr_load  <= LD_POWERUP;
      init_idx  <= 3'd0;
      lcd_en    <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_data  <= 8'h00;
      lcd_on    <= 1'b0;
    end else begin
      lcd_on    <= 1'b1;
      tmr_start <= 1'b0;
      case (state)
        POWERUP: if (tmr_done) state <= INIT;
        INIT: begin
          lcd_rs    <= 1'b0;
          lcd_data  <= INIT_ROM[init_idx[1:0]];
          init_idx  <= init_idx + 3'd1;
          state     <= SETUP;
          tmr_start <= 1'b1;
          tmr_load  <= LD_SETUP;
        end
        IDLE: if (accept_wr) begin
          lcd_rs    <= address;
          lcd_data  <= writedata;
          state     <= SETUP;
          tmr_start <= 1'b1;
          tmr_load  <= LD_SETUP;
        end
        SETUP: if (tmr_done) begin
          lcd_en    <= 1'b1;
          state     <= PULSE;
          tmr_start <= 1'b1;
          tmr_load  <= LD_PULSE;
        end
        PULSE: if (tmr_done) begin
          lcd_en    <= 1'b0;
          state     <= HOLD;
          tmr_start <= 1'b1;
          tmr_load  <= LD_HOLD;
        end
        HOLD: if (tmr_done) begin
          state     <= EXEC;
          tmr_start <= 1'b1;
          tmr_load  <= is_long_cmd(lcd_rs, lcd_data) ? LD_LONG : LD_SHORT;
        end
        EXEC: if (tmr_done) state <= (init_idx == 3'd4) ? IDLE : INIT;
        default: state <= POWERUP;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_avalon_ctrl.sv
// Self-checking bench for lcd_avalon_ctrl: a command-schedule model checked every cycle
// plus directed transfers with hand-computed timing and data expectations.
module tb_lcd_avalon_ctrl;

  localparam int T_ST  = 2;
  localparam int T_CMD = 6;

  logic       clk = 1'b0;
  logic       reset, address, chipselect, byteenable, read, write;
  logic [7:0] writedata;
  logic       waitrequest, lcd_rs, lcd_rw, lcd_en, lcd_on;
  logic [7:0] readdata, lcd_data;
  logic [1:0] response;

  lcd_avalon_ctrl #(
    .CLK_FREQ_HZ(1_000_000), .POWERUP_US(20), .T_SETUP_CYC(2), .T_PULSE_CYC(2),
    .T_HOLD_CYC(2), .EXEC_SHORT_US(5), .EXEC_LONG_US(30)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .byteenable(byteenable), .read(read), .write(write), .writedata(writedata),
    .waitrequest(waitrequest), .readdata(readdata), .response(response),
    .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_on(lcd_on)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rst_edges = 0;
  logic [7:0] init_rom [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rst_edges <= reset ? rst_edges + 1 : 0;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic int exec_len(input logic rs, input logic [7:0] d);
    return (!rs && d >= 8'h01 && d <= 8'h03) ? 30 : 5;
  endfunction

  // Model: list of commands with their first SETUP cycle; everything follows from that.
  typedef struct {
    int         start;
    logic [7:0] data;
    logic       rs;
  } cmd_t;

  cmd_t cmds[$];
  int   idle_from;
  int   base;
  bit   released = 0;

  always @(negedge clk) begin : compare
    cmd_t       c;
    int         s;
    logic       exp_en, exp_rs, idle;
    logic [7:0] exp_data, exp_rd;
    if (reset) begin
      released = 0;
      if (rst_edges > 0) begin
        checkOutput("rst_waitrequest", waitrequest, 1);
        checkOutput("rst_lcd_en", lcd_en, 0);
        checkOutput("rst_lcd_rs", lcd_rs, 0);
        checkOutput("rst_lcd_data", lcd_data, 0);
        checkOutput("rst_readdata", readdata, 0);
        checkOutput("rst_response", response, 0);
        checkOutput("rst_lcd_on", lcd_on, 0);
      end
    end else begin
      if (!released) begin
        released = 1;
        base = cyc;
        cmds.delete();
        s = base + 20 + 1;
        for (int k = 0; k < 4; k++) begin
          c.start = s; c.data = init_rom[k]; c.rs = 1'b0;
          cmds.push_back(c);
          s = s + T_CMD + exec_len(1'b0, init_rom[k]) + 1;
        end
        idle_from = s - 1;
      end
      exp_en = 0; exp_rs = 0; exp_data = 8'h00;
      foreach (cmds[i]) begin
        if (cmds[i].start <= cyc) begin
          exp_data = cmds[i].data;
          exp_rs   = cmds[i].rs;
        end
        if (cyc >= cmds[i].start + T_ST && cyc < cmds[i].start + T_ST + 2) exp_en = 1;
      end
      idle = (cyc >= idle_from);
      checkOutput("waitrequest", waitrequest, !(idle && chipselect && (read || write)));
      checkOutput("lcd_en", lcd_en, exp_en);
      checkOutput("lcd_data", lcd_data, exp_data);
      checkOutput("lcd_rs", lcd_rs, exp_rs);
      checkOutput("lcd_on", lcd_on, (cyc >= base + 1));
      checkOutput("lcd_rw", lcd_rw, 0);
      checkOutput("response", response, 0);
      if (chipselect && read) begin
        exp_rd = (!address && !write) ? {!idle, 7'b0} : 8'h00;
        checkOutput("readdata", readdata, exp_rd);
      end
      if (idle && chipselect && write) begin
        c.start = cyc + 1; c.data = writedata; c.rs = address;
        cmds.push_back(c);
        idle_from = cyc + 1 + T_CMD + exec_len(address, writedata);
      end
    end
  end

  int         rise_cyc[$];
  int         fall_cyc[$];
  logic [7:0] rise_data[$];
  logic       rise_rs[$];
  logic       en_prev = 0;

  always @(negedge clk) begin
    if (reset) begin
      rise_cyc.delete(); fall_cyc.delete(); rise_data.delete(); rise_rs.delete();
      en_prev = 0;
    end else begin
      if (lcd_en && !en_prev) begin
        rise_cyc.push_back(cyc); rise_data.push_back(lcd_data); rise_rs.push_back(lcd_rs);
      end
      if (!lcd_en && en_prev) fall_cyc.push_back(cyc);
      en_prev = lcd_en;
    end
  end

  task automatic applyStimulus(input logic addr, input logic rd, input logic wr, input logic [7:0] data,
                               input int budget, output int acc, output logic [7:0] rdval);
    @(posedge clk); #1;
    chipselect = 1; address = addr; read = rd; write = wr; writedata = data;
    acc = -1; rdval = 8'h00;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!waitrequest) begin
        acc = cyc; rdval = readdata;
        break;
      end
    end
    @(posedge clk); #1;
    chipselect = 0; read = 0; write = 0;
    checkOutput("accepted", (acc >= 0), 1);
  endtask

  task automatic checkInitPulses(input int rel);
    checkOutput("init_pulse_count", rise_cyc.size(), 4);
    if (rise_cyc.size() >= 4 && fall_cyc.size() >= 4) begin
      checkOutput("init_first_rise", rise_cyc[0] - rel, 23);
      for (int k = 0; k < 4; k++) begin
        checkOutput("init_data", rise_data[k], init_rom[k]);
        checkOutput("init_rs", rise_rs[k], 0);
        checkOutput("init_width", fall_cyc[k] - rise_cyc[k], 2);
      end
    end
  endtask

  initial begin : stim
    int         acc1, acc3, acc4a, acc4b, acc5a, acc5b, acc6, rel0, rel1;
    logic [7:0] rv;
    logic       seen;
    reset = 1; address = 0; chipselect = 0; byteenable = 1; read = 0; write = 0; writedata = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    rel0 = cyc;

    // Write issued during init stalls until the ROM has been played out.
    repeat (4) @(posedge clk);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h41, 300, acc1, rv);
    checkOutput("init_write_accept", acc1 - rel0, 93);
    checkInitPulses(rel0);
    if (fall_cyc.size() >= 4) checkOutput("long_gap", acc1 - fall_cyc[3], 32);

    applyStimulus(1'b1, 1'b0, 1'b1, 8'h4F, 60, acc3, rv);
    checkOutput("short_turnaround", acc3 - acc1, 12);
    repeat (6) @(posedge clk);
    checkOutput("pulse_count", rise_cyc.size(), 6);
    if (rise_cyc.size() >= 6 && fall_cyc.size() >= 6) begin
      checkOutput("rise_latency", rise_cyc[5] - acc3, 3);
      checkOutput("pulse_width", fall_cyc[5] - rise_cyc[5], 2);
      checkOutput("write_data", rise_data[5], 8'h4F);
      checkOutput("write_rs", rise_rs[5], 1);
    end

    applyStimulus(1'b0, 1'b0, 1'b1, 8'h01, 60, acc4a, rv);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h80, 60, acc4b, rv);
    checkOutput("clear_turnaround", acc4b - acc4a, 37);

    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 60, acc5a, rv);
    checkOutput("read_stall", acc5a - acc4b, 12);
    checkOutput("read_status", rv, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 60, acc5b, rv);
    checkOutput("read_idle_immediate", acc5b - acc5a, 2);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 60, acc5b, rv);
    checkOutput("read_addr1", rv, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h33, 60, acc5b, rv);
    checkOutput("rw_readdata", rv, 8'h00);
    repeat (6) @(posedge clk);
    if (rise_data.size() >= 9) checkOutput("rw_write_wins", rise_data[8], 8'h33);
    else checkOutput("rw_pulse_count", rise_data.size(), 9);

    // Reset in the middle of an enable pulse.
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h55, 60, acc6, rv);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (lcd_en) begin
        seen = 1;
        break;
      end
    end
    checkOutput("en_seen_before_reset", seen, 1);
    #1 reset = 1;
    @(negedge clk);
    checkOutput("abort_lcd_en", lcd_en, 0);
    checkOutput("abort_waitrequest", waitrequest, 1);
    repeat (2) @(posedge clk);
    #1 reset = 0;
    rel1 = cyc;
    repeat (100) @(posedge clk);
    checkInitPulses(rel1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

endmodule
